// File: rtl/uart_rx_ctrl_if.sv
// Byte stream from the UART receive controller to the host-side consumer.
// The controller drives rx_data/rx_valid; the consumer drives rx_ready.
interface uart_rx_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller.
// - Takes completed 11-bit frames from the serial receiver.
// - Checks the start, parity and stop bits.
// - Queues good bytes in a small FIFO with a valid/ready output.
// - Keeps sticky error flags and a count of good frames.
module uart_rx_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                          baud_clk,
    input  logic                          rst_n,
    input  logic [10:0]                   frame_in,
    input  logic                          frame_valid,
    uart_rx_ctrl_if.master                rx_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_err,
    output logic                          parity_err,
    output logic                          overrun_err,
    input  logic                          err_clr,
    output logic [7:0]                    frame_cnt
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_PUSH,
        S_DISCARD
    } state_t;

    state_t         state, next_state;
    logic           fv_q;
    logic           new_ev;
    logic [10:0]    frame_r;
    logic           fe, pe;
    logic           fifo_full;
    logic           latch_en, push, pop;
    logic           set_fe, set_pe, set_ov;
    logic [7:0]     wr_byte;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;

    // frame_valid is a level; only its rising edge marks a new frame
    assign new_ev = frame_valid && !fv_q;

    // Frame checks read the latched copy, which stays put through DISCARD
    assign fe = (frame_r[10] != 1'b0) || (frame_r[0] != 1'b1);
    assign pe = PARITY_EN && ((^frame_r[9:1]) != PARITY_ODD);

    assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
    assign pop       = rx_if.rx_valid && rx_if.rx_ready;

    assign rx_if.rx_valid = (fifo_count != '0);
    // Gate with rx_valid so the output reads 0 after reset and when empty
    assign rx_if.rx_data  = rx_if.rx_valid ? mem[rd_ptr] : 8'h00;

    // Reorder frame bits into a byte: d0 sits at frame bit 9, d7 at bit 2
    always_comb begin
        wr_byte = '0;
        for (int i = 0; i < 8; i++) begin
            wr_byte[i] = frame_r[9 - i];
        end
    end

    // Registered copy of frame_valid for edge detection
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) fv_q <= 1'b0;
        else        fv_q <= frame_valid;
    end

    // Capture the frame on an accepted new-frame event
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n)        frame_r <= '0;
        else if (latch_en) frame_r <= frame_in;
    end

    // FSM state register
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // FSM next state and per-state strobes
    always_comb begin
        next_state = state;
        latch_en   = 1'b0;
        push       = 1'b0;
        set_fe     = 1'b0;
        set_pe     = 1'b0;
        set_ov     = 1'b0;
        case (state)
            S_IDLE: begin
                if (new_ev) begin
                    latch_en   = 1'b1;
                    next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                // A bad frame is dropped for its own error even when the FIFO is full
                if (fe || pe)     next_state = S_DISCARD;
                else if (fifo_full) next_state = S_DISCARD;
                else              next_state = S_PUSH;
            end
            S_PUSH: begin
                push       = 1'b1;
                next_state = S_IDLE;
            end
            S_DISCARD: begin
                // DISCARD is reached only for fe, pe or full, so a clean frame here was an overrun
                set_fe     = fe;
                set_pe     = pe;
                set_ov     = !(fe || pe);
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        // The controller is single-frame; any event while busy is lost
        if (new_ev && (state != S_IDLE)) set_ov = 1'b1;
    end

    // Sticky error flags; clear wins over a same-cycle set
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            framing_err <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else if (err_clr) begin
            framing_err <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            framing_err <= framing_err | set_fe;
            parity_err  <= parity_err  | set_pe;
            overrun_err <= overrun_err | set_ov;
        end
    end

    // Good-frame counter, wraps naturally at 8 bits
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n)    frame_cnt <= 8'h00;
        else if (push) frame_cnt <= frame_cnt + 8'h01;
    end

    // FIFO storage; contents are don't-care until written, output is gated by rx_valid
    always_ff @(posedge baud_clk) begin
        if (push) mem[wr_ptr] <= wr_byte;
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely
    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (FIFO_DEPTH=4, even parity enabled).
module tb_uart_rx_ctrl;

    logic        baud_clk;
    logic        rst_n;
    logic [10:0] frame_in;
    logic        frame_valid;
    logic [2:0]  fifo_count;
    logic        framing_err, parity_err, overrun_err;
    logic        err_clr;
    logic [7:0]  frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_ctrl_if rx_if ();

    uart_rx_ctrl #(
        .FIFO_DEPTH (4),
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b0)
    ) dut (
        .baud_clk    (baud_clk),
        .rst_n       (rst_n),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .rx_if       (rx_if),
        .fifo_count  (fifo_count),
        .framing_err (framing_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err),
        .err_clr     (err_clr),
        .frame_cnt   (frame_cnt)
    );

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    task automatic tick;
        @(posedge baud_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame: start, d0..d7 at bits 9..2, even parity (optionally flipped), stop
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic st,
                                             input logic par_flip, input logic sp);
        logic [10:0] f;
        f[10] = st;
        for (int i = 0; i < 8; i++) f[9 - i] = d[i];
        f[1] = (^d) ^ par_flip;
        f[0] = sp;
        return f;
    endfunction

    // Event edge N, then N+1 and N+2; returns just after edge N+2
    task automatic send_frame(input logic [10:0] f);
        frame_in    = f;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        tick();
        tick();
    endtask

    logic [7:0] exp_bytes [4];

    initial begin
        rst_n          = 1'b0;
        frame_in       = '0;
        frame_valid    = 1'b0;
        rx_if.rx_ready = 1'b0;
        err_clr        = 1'b0;
        tick();
        tick();
        chk("rst_rx_valid",   rx_if.rx_valid, 0);
        chk("rst_rx_data",    rx_if.rx_data, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_errs",       {framing_err, parity_err, overrun_err}, 0);
        chk("rst_frame_cnt",  frame_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Good frame 0_10101010_0_1 -> byte 0x55
        rx_if.rx_ready = 1'b1;
        frame_in    = 11'b0_10101010_0_1;
        frame_valid = 1'b1;
        tick();                              // N
        frame_valid = 1'b0;
        tick();                              // N+1
        chk("good_n1_valid", rx_if.rx_valid, 0);
        tick();                              // N+2
        chk("good_valid",     rx_if.rx_valid, 1);
        chk("good_data",      rx_if.rx_data, 8'h55);
        chk("good_frame_cnt", frame_cnt, 1);
        chk("good_errs",      {framing_err, parity_err, overrun_err}, 0);
        tick();                              // popped
        chk("good_popped",    fifo_count, 0);
        rx_if.rx_ready = 1'b0;

        // Parity error
        frame_in    = 11'b0_10101010_1_1;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        tick();
        chk("par_n1_clear", parity_err, 0);
        tick();
        chk("par_err",       parity_err, 1);
        chk("par_count",     fifo_count, 0);
        chk("par_frame_cnt", frame_cnt, 1);
        chk("par_no_fe",     framing_err, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("par_cleared",   parity_err, 0);

        // Framing error: start 1, stop 0, parity fine
        send_frame(11'b1_10101010_0_0);
        chk("fe_flag",  framing_err, 1);
        chk("fe_no_pe", parity_err, 0);
        chk("fe_count", fifo_count, 0);
        // Framing and parity errors together
        send_frame(11'b1_10101010_1_0);
        chk("fepe_flags", {framing_err, parity_err, overrun_err}, 3'b110);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Overrun by full FIFO: five good frames, no consumer
        for (int i = 1; i <= 5; i++) begin
            send_frame(mk_frame(8'(i), 1'b0, 1'b0, 1'b1));
            tick();
        end
        chk("full_count",     fifo_count, 4);
        chk("full_overrun",   overrun_err, 1);
        chk("full_frame_cnt", frame_cnt, 5);
        chk("full_head",      rx_if.rx_data, 8'h01);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Pop at the event edge frees a slot before CHECK sees occupancy
        frame_in       = mk_frame(8'h06, 1'b0, 1'b0, 1'b1);
        frame_valid    = 1'b1;
        rx_if.rx_ready = 1'b1;
        tick();                              // N: pops 0x01
        rx_if.rx_ready = 1'b0;
        frame_valid    = 1'b0;
        chk("pf_count_n", fifo_count, 3);
        tick();
        tick();
        chk("pf_count",     fifo_count, 4);
        chk("pf_overrun",   overrun_err, 0);
        chk("pf_frame_cnt", frame_cnt, 6);
        exp_bytes[0] = 8'h02;
        exp_bytes[1] = 8'h03;
        exp_bytes[2] = 8'h04;
        exp_bytes[3] = 8'h06;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_%0d", i), rx_if.rx_data, exp_bytes[i]);
            rx_if.rx_ready = 1'b1;
            tick();
        end
        chk("drain_empty", rx_if.rx_valid, 0);
        // Pop on empty is ignored
        tick();
        chk("empty_pop_count", fifo_count, 0);
        rx_if.rx_ready = 1'b0;

        // Push and pop on the same edge
        send_frame(mk_frame(8'h21, 1'b0, 1'b0, 1'b1));
        tick();
        frame_in    = mk_frame(8'h22, 1'b0, 1'b0, 1'b1);
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        tick();
        rx_if.rx_ready = 1'b1;
        tick();                              // N+2: push 0x22, pop 0x21
        rx_if.rx_ready = 1'b0;
        chk("pp_count", fifo_count, 1);
        chk("pp_data",  rx_if.rx_data, 8'h22);
        chk("pp_frame_cnt", frame_cnt, 8);
        rx_if.rx_ready = 1'b1;
        tick();
        rx_if.rx_ready = 1'b0;

        // Second edge two cycles after the first is dropped
        frame_in    = mk_frame(8'h33, 1'b0, 1'b0, 1'b1);
        frame_valid = 1'b1;
        tick();                              // N
        frame_valid = 1'b0;
        tick();                              // N+1
        frame_in    = mk_frame(8'h44, 1'b0, 1'b0, 1'b1);
        frame_valid = 1'b1;
        tick();                              // N+2, busy
        frame_valid = 1'b0;
        chk("busy_overrun",   overrun_err, 1);
        chk("busy_frame_cnt", frame_cnt, 9);
        tick();
        tick();
        tick();
        chk("busy_count", fifo_count, 1);
        chk("busy_data",  rx_if.rx_data, 8'h33);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("busy_cleared", overrun_err, 0);

        // Clear on the DISCARD edge beats the new parity error
        frame_in    = mk_frame(8'h77, 1'b0, 1'b1, 1'b1);
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("clr_prio_pe",    parity_err, 0);
        chk("clr_prio_count", fifo_count, 1);

        // Reset during CHECK
        frame_in    = mk_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        frame_valid = 1'b1;
        tick();                              // N: now in CHECK
        frame_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",     rx_if.rx_valid, 0);
        chk("mid_rst_data",      rx_if.rx_data, 0);
        chk("mid_rst_count",     fifo_count, 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rst_no_push", fifo_count, 0);
        send_frame(mk_frame(8'h5A, 1'b0, 1'b0, 1'b1));
        chk("post_rst_data",      rx_if.rx_data, 8'h5A);
        chk("post_rst_frame_cnt", frame_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
